amt_commit_recover: RTL and testbench

//  Parametrised architectural map table (AMT). Sits between ActiveList commit and the

---
 rtl/amt_pkg.sv | 21 ++
 rtl/amt_dedup.sv | 23 ++
 rtl/amt_commit_recover.sv | 117 +++++++++++
 tb/tb_amt_commit_recover.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/amt_pkg.sv
// Shared types and helpers for the architectural map table and its recovery walk.
package amt_pkg;

    function automatic int amt_log_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic [1:0] {
        AMT_IDLE = 2'd0,
        AMT_WALK = 2'd1,
        AMT_DONE = 2'd2
    } amt_state_e;

    // Widest lane supported by the packet views; narrower configs zero-extend.
    typedef struct packed {
        logic       vld;
        logic [7:0] log_idx;
        logic [7:0] phys;
    } amt_lane_t;

endpackage

// File: rtl/amt_dedup.sv
// Flags commit lanes whose mapping is overwritten by a younger valid lane in the same group.
module amt_dedup
    import amt_pkg::*;
#(
    parameter int COMMIT_WIDTH = 4,
    parameter int LOG_W        = 5
) (
    input  logic [COMMIT_WIDTH-1:0]       i_valid,
    input  logic [COMMIT_WIDTH*LOG_W-1:0] i_log,
    output logic [COMMIT_WIDTH-1:0]       o_shadow
);

    always_comb begin
        o_shadow = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            for (int j = i + 1; j < COMMIT_WIDTH; j++) begin
                if (i_valid[j] && (i_log[j*LOG_W +: LOG_W] == i_log[i*LOG_W +: LOG_W]))
                    o_shadow[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/amt_commit_recover.sv
// Architectural map table: absorbs retiring mappings, releases displaced tags,
// and streams the whole table to the RMT on a recovery request.
module amt_commit_recover
    import amt_pkg::*;
#(
    parameter int COMMIT_WIDTH  = 4,
    parameter int NUM_LOG       = 32,
    parameter int PHYS_W        = 7,
    parameter int RECOVER_WIDTH = 4,
    localparam int LOG_W        = amt_log_w(NUM_LOG)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [COMMIT_WIDTH-1:0]           commit_valid_i,
    input  logic [COMMIT_WIDTH*LOG_W-1:0]     commit_log_i,
    input  logic [COMMIT_WIDTH*PHYS_W-1:0]    commit_phys_i,
    output logic                              commit_ready_o,
    input  logic                              recover_req_i,
    output logic [COMMIT_WIDTH-1:0]           released_valid_o,
    output logic [COMMIT_WIDTH*PHYS_W-1:0]    released_phys_o,
    output logic                              recover_valid_o,
    output logic [RECOVER_WIDTH-1:0]          recover_lane_vld_o,
    output logic [RECOVER_WIDTH*LOG_W-1:0]    recover_log_o,
    output logic [RECOVER_WIDTH*PHYS_W-1:0]   recover_phys_o,
    output logic                              recover_busy_o,
    output logic                              recover_done_o
);

    logic [PHYS_W-1:0]   r_amt [NUM_LOG];
    amt_state_e          r_state;
    logic [LOG_W:0]      r_cnt;

    logic [COMMIT_WIDTH-1:0] w_shadow;
    logic [COMMIT_WIDTH-1:0] w_we;
    logic [LOG_W-1:0]        w_clog [COMMIT_WIDTH];
    logic [LOG_W+1:0]        w_ridx [RECOVER_WIDTH];
    logic                    w_ready;
    logic                    w_walk;
    logic                    w_last;

    amt_dedup #(
        .COMMIT_WIDTH (COMMIT_WIDTH),
        .LOG_W        (LOG_W)
    ) u_dedup (
        .i_valid  (commit_valid_i),
        .i_log    (commit_log_i),
        .o_shadow (w_shadow)
    );

    assign w_walk  = (r_state == AMT_WALK);
    assign w_ready = !w_walk;
    assign w_last  = (32'(r_cnt) + RECOVER_WIDTH) >= NUM_LOG;

    assign commit_ready_o  = w_ready;
    assign recover_valid_o = w_walk;
    assign recover_busy_o  = w_walk;
    assign recover_done_o  = (r_state == AMT_DONE);

    // Shadowed lanes hand back their own tag: it was never architecturally visible.
    always_comb begin
        released_valid_o = commit_valid_i & {COMMIT_WIDTH{w_ready}};
        released_phys_o  = '0;
        w_we             = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            w_clog[i] = commit_log_i[i*LOG_W +: LOG_W];
            if (w_shadow[i])
                released_phys_o[i*PHYS_W +: PHYS_W] = commit_phys_i[i*PHYS_W +: PHYS_W];
            else if (32'(w_clog[i]) < NUM_LOG)
                released_phys_o[i*PHYS_W +: PHYS_W] = r_amt[w_clog[i]];
            w_we[i] = commit_valid_i[i] && w_ready && !w_shadow[i] && (32'(w_clog[i]) < NUM_LOG);
        end
    end

    always_comb begin
        recover_lane_vld_o = '0;
        recover_log_o      = '0;
        recover_phys_o     = '0;
        for (int k = 0; k < RECOVER_WIDTH; k++) begin
            w_ridx[k] = (LOG_W+2)'(r_cnt) + (LOG_W+2)'(k);
            if (w_walk && (32'(w_ridx[k]) < NUM_LOG)) begin
                recover_lane_vld_o[k]                = 1'b1;
                recover_log_o[k*LOG_W +: LOG_W]      = w_ridx[k][LOG_W-1:0];
                recover_phys_o[k*PHYS_W +: PHYS_W]   = r_amt[w_ridx[k][LOG_W-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_LOG; i++)
                r_amt[i] <= PHYS_W'(i);
            r_state <= AMT_IDLE;
            r_cnt   <= '0;
        end else begin
            for (int i = 0; i < COMMIT_WIDTH; i++) begin
                if (w_we[i])
                    r_amt[w_clog[i]] <= commit_phys_i[i*PHYS_W +: PHYS_W];
            end
            case (r_state)
                AMT_IDLE: begin
                    if (recover_req_i) begin
                        r_state <= AMT_WALK;
                        r_cnt   <= '0;
                    end
                end
                AMT_WALK: begin
                    r_cnt <= r_cnt + (LOG_W+1)'(RECOVER_WIDTH);
                    if (w_last)
                        r_state <= AMT_DONE;
                end
                AMT_DONE: r_state <= AMT_IDLE;
                default:  r_state <= AMT_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_amt_commit_recover.sv
// Directed bench for amt_commit_recover: a reference map table predicts releases and walk beats.
module tb_amt_commit_recover;

    localparam int CW  = 4;
    localparam int NL  = 32;
    localparam int PW  = 7;
    localparam int RW  = 4;
    localparam int LW  = 5;
    localparam int NL1 = 34;
    localparam int LW1 = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset = 1'b1;
    logic [CW-1:0]        commit_valid = '0;
    logic [CW*LW-1:0]     commit_log = '0;
    logic [CW*PW-1:0]     commit_phys = '0;
    logic                 recover_req = 1'b0;
    logic                 commit_ready;
    logic [CW-1:0]        released_valid;
    logic [CW*PW-1:0]     released_phys;
    logic                 recover_valid;
    logic [RW-1:0]        lane_vld;
    logic [RW*LW-1:0]     rec_log;
    logic [RW*PW-1:0]     rec_phys;
    logic                 busy;
    logic                 done;

    logic [CW-1:0]        d1_cv = '0;
    logic [CW*LW1-1:0]    d1_cl = '0;
    logic [CW*PW-1:0]     d1_cp = '0;
    logic                 d1_req = 1'b0;
    logic                 d1_ready;
    logic [CW-1:0]        d1_rv;
    logic [CW*PW-1:0]     d1_rp;
    logic                 d1_valid;
    logic [RW-1:0]        d1_lane_vld;
    logic [RW*LW1-1:0]    d1_log;
    logic [RW*PW-1:0]     d1_phys;
    logic                 d1_busy;
    logic                 d1_done;

    amt_commit_recover #(.COMMIT_WIDTH(CW), .NUM_LOG(NL), .PHYS_W(PW), .RECOVER_WIDTH(RW)) dut (
        .clk(clk), .reset(reset),
        .commit_valid_i(commit_valid), .commit_log_i(commit_log), .commit_phys_i(commit_phys),
        .commit_ready_o(commit_ready), .recover_req_i(recover_req),
        .released_valid_o(released_valid), .released_phys_o(released_phys),
        .recover_valid_o(recover_valid), .recover_lane_vld_o(lane_vld),
        .recover_log_o(rec_log), .recover_phys_o(rec_phys),
        .recover_busy_o(busy), .recover_done_o(done)
    );

    amt_commit_recover #(.COMMIT_WIDTH(CW), .NUM_LOG(NL1), .PHYS_W(PW), .RECOVER_WIDTH(RW)) dut1 (
        .clk(clk), .reset(reset),
        .commit_valid_i(d1_cv), .commit_log_i(d1_cl), .commit_phys_i(d1_cp),
        .commit_ready_o(d1_ready), .recover_req_i(d1_req),
        .released_valid_o(d1_rv), .released_phys_o(d1_rp),
        .recover_valid_o(d1_valid), .recover_lane_vld_o(d1_lane_vld),
        .recover_log_o(d1_log), .recover_phys_o(d1_phys),
        .recover_busy_o(d1_busy), .recover_done_o(d1_done)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] exp_q[$];
    logic [PW-1:0] m_amt [NL];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] obs_beat(input bit sel);
        if (sel) return 64'({d1_lane_vld, d1_log, d1_phys});
        return 64'({lane_vld, rec_log, rec_phys});
    endfunction

    function automatic logic [63:0] exp_beat(input bit sel, input int cnt);
        int nl = sel ? NL1 : NL;
        int lw = sel ? LW1 : LW;
        logic [63:0] vb = '0, lg = '0, ph = '0;
        for (int k = 0; k < RW; k++) begin
            int idx = cnt + k;
            if (idx < nl) begin
                vb[k] = 1'b1;
                lg = lg | (64'(idx) << (k * lw));
                if (sel) ph = ph | (64'(idx) << (k * PW));
                else     ph = ph | (64'(m_amt[idx]) << (k * PW));
            end
        end
        return (vb << (RW * lw + RW * PW)) | (lg << (RW * PW)) | ph;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NL; i++) m_amt[i] = PW'(i);
    endtask

    task automatic model_commit(input logic [CW-1:0] v, input logic [CW*LW-1:0] l,
                                input logic [CW*PW-1:0] p, output logic [CW*PW-1:0] exp_rp);
        logic [CW-1:0] wr = '0;
        exp_rp = '0;
        for (int i = 0; i < CW; i++) begin
            logic sh = 1'b0;
            for (int j = i + 1; j < CW; j++)
                if (v[j] && l[j*LW +: LW] == l[i*LW +: LW]) sh = 1'b1;
            if (v[i]) begin
                exp_rp[i*PW +: PW] = sh ? p[i*PW +: PW] : m_amt[l[i*LW +: LW]];
                wr[i] = !sh;
            end
        end
        for (int i = 0; i < CW; i++)
            if (wr[i]) m_amt[l[i*LW +: LW]] = p[i*PW +: PW];
    endtask

    task automatic do_commit(input logic [CW-1:0] v, input logic [CW*LW-1:0] l, input logic [CW*PW-1:0] p);
        logic [CW*PW-1:0] exp_rp, mask;
        @(negedge clk);
        commit_valid = v; commit_log = l; commit_phys = p;
        model_commit(v, l, p, exp_rp);
        mask = '0;
        for (int i = 0; i < CW; i++) if (v[i]) mask[i*PW +: PW] = '1;
        #1;
        chk("rel_valid", 64'(released_valid), 64'(v));
        chk("rel_phys", 64'(released_phys & mask), 64'(exp_rp));
        @(negedge clk);
        commit_valid = '0;
    endtask

    task automatic do_walk(input bit sel, input int nb, input bit noisy,
                           input logic [CW-1:0] v, input logic [CW*LW-1:0] l, input logic [CW*PW-1:0] p);
        logic [CW*PW-1:0] exp_rp;
        int  beats = 0;
        bit  done_seen = 0;
        @(negedge clk);
        if (sel) d1_req = 1'b1;
        else begin
            recover_req = 1'b1;
            commit_valid = v; commit_log = l; commit_phys = p;
            model_commit(v, l, p, exp_rp);
        end
        for (int b = 0; b < nb; b++) exp_q.push_back(exp_beat(sel, b * RW));
        #1;
        if (!sel && v != '0) chk("req_cycle_rel_valid", 64'(released_valid), 64'(v));
        for (int t = 0; t < nb + 4 && !done_seen; t++) begin
            @(negedge clk);
            recover_req = 1'b0; d1_req = 1'b0;
            if (noisy && t < nb) begin
                commit_valid = CW'($urandom_range(1, (1 << CW) - 1));
                commit_log   = (CW*LW)'($urandom);
                commit_phys  = (CW*PW)'($urandom);
            end else commit_valid = '0;
            #1;
            if (sel ? d1_valid : recover_valid) begin
                if (exp_q.size() == 0) chk("extra_beat", 64'(beats), 64'(nb - 1));
                else chk("beat", obs_beat(sel), exp_q.pop_front());
                beats++;
                if (!sel) chk("ready_in_walk", 64'(commit_ready), 64'(0));
                if (noisy) chk("rel_valid_in_walk", 64'(released_valid), 64'(0));
            end else if (sel ? d1_done : done) begin
                done_seen = 1;
                chk("beats_before_done", 64'(beats), 64'(nb));
                chk("busy_in_done", 64'(sel ? d1_busy : busy), 64'(0));
                if (!sel) chk("ready_in_done", 64'(commit_ready), 64'(1));
            end
        end
        commit_valid = '0;
        chk("done_seen", 64'(done_seen), 64'(1));
        chk("queue_drained", 64'(exp_q.size()), 64'(0));
        exp_q.delete();
        @(negedge clk);
        #1;
        chk("done_one_cycle", 64'(sel ? d1_done : done), 64'(0));
        chk("idle_after_walk", 64'(sel ? d1_busy : busy), 64'(0));
    endtask

    initial begin
        int done_cnt;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset_ready", 64'(commit_ready), 64'(1));
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_done", 64'(done), 64'(0));
        chk("reset_valid", 64'(recover_valid), 64'(0));
        chk("reset_rel_valid", 64'(released_valid), 64'(0));

        // Identity walk on the default geometry, then 34 entries (partial last beat).
        do_walk(0, 8, 0, '0, '0, '0);
        do_walk(1, 9, 0, '0, '0, '0);

        // Two independent commits.
        do_commit(4'b0011, {5'd0, 5'd0, 5'd7, 5'd3}, {7'd0, 7'd0, 7'd41, 7'd40});
        do_walk(0, 8, 0, '0, '0, '0);

        // Duplicate r5 in lanes 0 and 2 with an invalid r5 in between.
        do_commit(4'b0101, {5'd0, 5'd5, 5'd5, 5'd5}, {7'd0, 7'd51, 7'd99, 7'd50});

        // Clustered random commits to exercise intra-group duplicates.
        for (int n = 0; n < 16; n++) begin
            logic [CW*LW-1:0] rl;
            logic [CW*PW-1:0] rp;
            for (int i = 0; i < CW; i++) begin
                rl[i*LW +: LW] = LW'($urandom_range(8, 11));
                rp[i*PW +: PW] = PW'($urandom_range(0, 127));
            end
            do_commit(CW'($urandom_range(0, 15)), rl, rp);
        end
        do_walk(0, 8, 0, '0, '0, '0);

        // Request with a same-cycle commit; commits offered during the walk are dropped.
        do_walk(0, 8, 1, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd0}, {7'd0, 7'd0, 7'd0, 7'd60});
        do_walk(0, 8, 0, '0, '0, '0);

        // Reset while beat 3 is on the bus.
        @(negedge clk);
        recover_req = 1'b1;
        for (int b = 0; b < 4; b++) exp_q.push_back(exp_beat(0, b * RW));
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            recover_req = 1'b0;
            #1;
            if (recover_valid) chk("abort_beat", obs_beat(0), exp_q.pop_front());
            else chk("abort_beat_present", 64'(recover_valid), 64'(1));
        end
        exp_q.delete();
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_valid", 64'(recover_valid), 64'(0));
        reset = 1'b0;
        model_reset();
        done_cnt = (done === 1'b1) ? 1 : 0;
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            #1;
            if (done !== 1'b0) done_cnt++;
        end
        chk("abort_no_done", 64'(done_cnt), 64'(0));
        do_walk(0, 8, 0, '0, '0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
